// File: rtl/data_mem_responder_if.sv
// Core data-memory request/grant/rvalid bus.
// The core drives the master side; the memory responder sits on the slave side.
interface data_mem_responder_if #(
    parameter int WORD_WIDTH = 32
);
    logic                  data_req_i;
    logic [WORD_WIDTH-1:0] data_addr_i;
    logic                  data_we_i;
    logic [3:0]            data_be_i;
    logic [WORD_WIDTH-1:0] data_wdata_i;
    logic                  data_gnt_o;
    logic                  data_rvalid_o;
    logic [WORD_WIDTH-1:0] data_rdata_o;
    logic                  data_err_o;

    modport master (
        output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );

    modport slave (
        input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: byte-enabled word array with a fixed-latency response pipe.
// Optional grant wait states when MEM_GNT_STALL_EN is defined.
module data_mem_responder #(
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int RESP_LAT   = 1,
    parameter int GNT_STALL  = 2
) (
    input  logic clk,
    input  logic rst_n,
    data_mem_responder_if.slave bus
);
    localparam int AW        = $clog2(DEPTH);
    localparam int NUM_LANES = WORD_WIDTH / 8;

    logic [WORD_WIDTH-3:0]             idx;
    logic [AW-1:0]                     widx;
    logic                              in_range;
    logic                              gnt_raw;
    logic                              accept;
    logic [WORD_WIDTH-1:0]             rd_word;
    logic [NUM_LANES-1:0][7:0]         mem [DEPTH];

    logic [RESP_LAT-1:0]                 vld_pipe;
    logic [RESP_LAT-1:0]                 err_pipe;
    logic [RESP_LAT-1:0][WORD_WIDTH-1:0] dat_pipe;

    logic unused_addr_lsb;

    assign idx             = bus.data_addr_i[WORD_WIDTH-1:2];
    assign widx            = idx[AW-1:0];
    assign in_range        = (idx >> AW) == '0;
    assign unused_addr_lsb = ^bus.data_addr_i[1:0];

`ifdef MEM_GNT_STALL_EN
    typedef enum logic {IDLE, WAIT} state_t;
    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The IDLE cycle that sees the request already counts as the first wait cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gnt_raw   = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (bus.data_req_i) begin
                    if (GNT_STALL == 0) begin
                        gnt_raw = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = 4'd1;
                    end
                end
            end
            WAIT: begin
                if (!bus.data_req_i) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == 4'(GNT_STALL)) begin
                    gnt_raw   = 1'b1;
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
`else
    logic unused_gnt_stall;
    assign unused_gnt_stall = (GNT_STALL != 0);
    assign gnt_raw          = bus.data_req_i;
`endif

    assign bus.data_gnt_o = rst_n & gnt_raw;
    assign accept         = bus.data_req_i & bus.data_gnt_o;

    // Array is deliberately not reset; only in-range write accepts touch it.
    always_ff @(posedge clk) begin
        if (accept && bus.data_we_i && in_range) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (bus.data_be_i[l]) mem[widx][l] <= bus.data_wdata_i[8*l +: 8];
            end
        end
    end

    assign rd_word = (accept && !bus.data_we_i && in_range) ? mem[widx] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            err_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[0] <= accept;
            err_pipe[0] <= accept & ~in_range;
            dat_pipe[0] <= rd_word;
            for (int i = 1; i < RESP_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                err_pipe[i] <= err_pipe[i-1];
                dat_pipe[i] <= dat_pipe[i-1];
            end
        end
    end

    assign bus.data_rvalid_o = vld_pipe[RESP_LAT-1];
    assign bus.data_rdata_o  = vld_pipe[RESP_LAT-1] ? dat_pipe[RESP_LAT-1] : '0;
    assign bus.data_err_o    = vld_pipe[RESP_LAT-1] & err_pipe[RESP_LAT-1];
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: three responders (RESP_LAT 1/2/3) share one stimulus stream.
module tb_data_mem_responder;
`ifdef MEM_GNT_STALL_EN
    localparam int EXP_WAIT = 2;
`else
    localparam int EXP_WAIT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  be = '0;
    int          cyc = 0;
    int          vectors = 0, miscompares = 0, idle_bad = 0;

    typedef struct { int c; logic [31:0] d; logic e; } resp_t;
    resp_t q1[$], q2[$], q3[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder_if #(.WORD_WIDTH(32)) if1();
    data_mem_responder_if #(.WORD_WIDTH(32)) if2();
    data_mem_responder_if #(.WORD_WIDTH(32)) if3();

    assign if1.data_req_i = req;  assign if1.data_addr_i = addr;  assign if1.data_we_i = we;
    assign if1.data_be_i  = be;   assign if1.data_wdata_i = wdata;
    assign if2.data_req_i = req;  assign if2.data_addr_i = addr;  assign if2.data_we_i = we;
    assign if2.data_be_i  = be;   assign if2.data_wdata_i = wdata;
    assign if3.data_req_i = req;  assign if3.data_addr_i = addr;  assign if3.data_we_i = we;
    assign if3.data_be_i  = be;   assign if3.data_wdata_i = wdata;

    data_mem_responder #(.WORD_WIDTH(32), .DEPTH(1024), .RESP_LAT(1), .GNT_STALL(2))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    data_mem_responder #(.WORD_WIDTH(32), .DEPTH(1024), .RESP_LAT(2), .GNT_STALL(2))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    data_mem_responder #(.WORD_WIDTH(32), .DEPTH(1024), .RESP_LAT(3), .GNT_STALL(2))
        dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    always @(negedge clk) begin
        if (if1.data_rvalid_o) q1.push_back('{cyc, if1.data_rdata_o, if1.data_err_o});
        else if (if1.data_rdata_o !== 32'h0 || if1.data_err_o !== 1'b0) idle_bad++;
        if (if2.data_rvalid_o) q2.push_back('{cyc, if2.data_rdata_o, if2.data_err_o});
        else if (if2.data_rdata_o !== 32'h0 || if2.data_err_o !== 1'b0) idle_bad++;
        if (if3.data_rvalid_o) q3.push_back('{cyc, if3.data_rdata_o, if3.data_err_o});
        else if (if3.data_rdata_o !== 32'h0 || if3.data_err_o !== 1'b0) idle_bad++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_q();
        q1.delete(); q2.delete(); q3.delete();
    endtask

    // Called at a negedge; holds the request until granted, returns at the next negedge.
    task automatic access(input logic w, input logic [31:0] a, input logic [3:0] b,
                          input logic [31:0] d, output int acc, output int waited);
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        acc = -1; waited = 0;
        while (acc < 0 && waited < 40) begin
            #1;
            if (if1.data_gnt_o === 1'b1) acc = cyc;
            @(negedge clk);
            if (acc < 0) waited++;
        end
        req = 1'b0;
        if (acc < 0) begin
            vectors++; miscompares++;
            $display("FAIL gnt_timeout addr=%h: no grant seen, required grant within 40 cycles", a);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h0;
        #1;
        vectors++;
        if (if1.data_gnt_o !== 1'b0) begin
            miscompares++; $display("FAIL reset_gnt got %b want 0", if1.data_gnt_o);
        end
        vectors++;
        if ({if1.data_rvalid_o, if2.data_rvalid_o, if3.data_rvalid_o} !== 3'b000) begin
            miscompares++; $display("FAIL reset_rvalid got %b%b%b want 000",
                if1.data_rvalid_o, if2.data_rvalid_o, if3.data_rvalid_o);
        end
        vectors++;
        if (if3.data_rdata_o !== 32'h0 || if3.data_err_o !== 1'b0) begin
            miscompares++; $display("FAIL reset_rdata_err got %h/%b want 0/0", if3.data_rdata_o, if3.data_err_o);
        end
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_read_after_write();
        int a0, a1, w0, w1;
        clear_q();
        access(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, a0, w0);
        access(1'b0, 32'h10, 4'hF, 32'h0, a1, w1);
        idle(5);
        vectors++;
        if (w0 != EXP_WAIT || w1 != EXP_WAIT) begin
            miscompares++; $display("FAIL raw_gnt_wait got %0d/%0d want %0d", w0, w1, EXP_WAIT);
        end
        vectors++;
        if (q1.size() != 2) begin
            miscompares++; $display("FAIL raw_resp_count got %0d want 2", q1.size());
        end
        vectors++;
        if (q1[0].c != a0 + 1 || q1[0].d !== 32'h0 || q1[0].e !== 1'b0) begin
            miscompares++; $display("FAIL raw_write_resp got c=%0d d=%h e=%b want c=%0d d=0 e=0",
                q1[0].c, q1[0].d, q1[0].e, a0 + 1);
        end
        vectors++;
        if (q1[1].c != a1 + 1 || q1[1].d !== 32'hDEADBEEF || q1[1].e !== 1'b0) begin
            miscompares++; $display("FAIL raw_read_resp got c=%0d d=%h e=%b want c=%0d d=deadbeef e=0",
                q1[1].c, q1[1].d, q1[1].e, a1 + 1);
        end
        vectors++;
        if (q3[1].c != a1 + 3 || q3[1].d !== 32'hDEADBEEF) begin
            miscompares++; $display("FAIL raw_read_lat3 got c=%0d d=%h want c=%0d d=deadbeef",
                q3[1].c, q3[1].d, a1 + 3);
        end
    endtask

    task automatic test_byte_enable();
        int a[5], w;
        clear_q();
        access(1'b1, 32'h20, 4'hF,    32'h11223344, a[0], w);
        access(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, a[1], w);
        access(1'b0, 32'h20, 4'h0,    32'h0,        a[2], w);
        access(1'b1, 32'h20, 4'h0,    32'hFFFFFFFF, a[3], w);
        access(1'b0, 32'h22, 4'h0,    32'h0,        a[4], w);
        idle(5);
        vectors++;
        if (q2.size() != 5) begin
            miscompares++; $display("FAIL be_resp_count got %0d want 5", q2.size());
        end
        vectors++;
        if (q2[2].c != a[2] + 2 || q2[2].d !== 32'h11BB33DD) begin
            miscompares++; $display("FAIL be_merge got c=%0d d=%h want c=%0d d=11bb33dd",
                q2[2].c, q2[2].d, a[2] + 2);
        end
        vectors++;
        if (q2[3].d !== 32'h0 || q2[4].d !== 32'h11BB33DD || q2[4].e !== 1'b0) begin
            miscompares++; $display("FAIL be_zero_write got wr=%h rd=%h e=%b want 0/11bb33dd/0",
                q2[3].d, q2[4].d, q2[4].e);
        end
    endtask

    task automatic test_out_of_range();
        int a[7], w;
        clear_q();
        access(1'b1, 32'h0,      4'hF, 32'h55AA55AA, a[0], w);
        access(1'b0, 32'h1000,   4'hF, 32'h0,        a[1], w);
        access(1'b1, 32'h1000,   4'hF, 32'hFFFFFFFF, a[2], w);
        access(1'b0, 32'h0,      4'hF, 32'h0,        a[3], w);
        access(1'b1, 32'hFFC,    4'hF, 32'h12345678, a[4], w);
        access(1'b0, 32'hFFC,    4'hF, 32'h0,        a[5], w);
        access(1'b0, 32'hFFFFFFFC, 4'hF, 32'h0,      a[6], w);
        idle(5);
        vectors++;
        if (q1[1].d !== 32'h0 || q1[1].e !== 1'b1) begin
            miscompares++; $display("FAIL oob_read got d=%h e=%b want 0/1", q1[1].d, q1[1].e);
        end
        vectors++;
        if (q1[2].d !== 32'h0 || q1[2].e !== 1'b1) begin
            miscompares++; $display("FAIL oob_write got d=%h e=%b want 0/1", q1[2].d, q1[2].e);
        end
        vectors++;
        if (q1[3].d !== 32'h55AA55AA || q1[3].e !== 1'b0) begin
            miscompares++; $display("FAIL oob_no_alias got d=%h e=%b want 55aa55aa/0", q1[3].d, q1[3].e);
        end
        vectors++;
        if (q1[5].d !== 32'h12345678 || q1[5].e !== 1'b0) begin
            miscompares++; $display("FAIL last_index got d=%h e=%b want 12345678/0", q1[5].d, q1[5].e);
        end
        vectors++;
        if (q1[6].d !== 32'h0 || q1[6].e !== 1'b1 || q1.size() != 7) begin
            miscompares++; $display("FAIL oob_high got d=%h e=%b n=%0d want 0/1/7", q1[6].d, q1[6].e, q1.size());
        end
    endtask

    task automatic test_back_to_back();
        int a[4], w;
        for (int i = 0; i < 4; i++) access(1'b1, 32'(4 * i), 4'hF, 32'(i + 1), a[i], w);
        idle(4);
        clear_q();
        for (int i = 0; i < 4; i++) access(1'b0, 32'(4 * i), 4'hF, 32'h0, a[i], w);
        idle(6);
        vectors++;
        if (q2.size() != 4) begin
            miscompares++; $display("FAIL b2b_count got %0d want 4", q2.size());
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (q2[i].c != a[i] + 2 || q2[i].d !== 32'(i + 1)) begin
                miscompares++; $display("FAIL b2b_resp%0d got c=%0d d=%h want c=%0d d=%h",
                    i, q2[i].c, q2[i].d, a[i] + 2, 32'(i + 1));
            end
        end
`ifndef MEM_GNT_STALL_EN
        vectors++;
        if (a[3] != a[0] + 3 || q2[3].c != q2[0].c + 3) begin
            miscompares++; $display("FAIL b2b_throughput got span acc=%0d rv=%0d want 3/3",
                a[3] - a[0], q2[3].c - q2[0].c);
        end
`endif
    endtask

    task automatic test_reset_midflight();
        int a, ar, w;
        clear_q();
        access(1'b0, 32'h0, 4'hF, 32'h0, a, w);
        #2 rst_n = 1'b0;
        idle(1);
        #1;
        vectors++;
        if ({if2.data_rvalid_o, if3.data_rvalid_o} !== 2'b00 || if3.data_rdata_o !== 32'h0) begin
            miscompares++; $display("FAIL midreset_outputs got rv=%b%b d=%h want 00/0",
                if2.data_rvalid_o, if3.data_rvalid_o, if3.data_rdata_o);
        end
        idle(2);
        rst_n = 1'b1;
        idle(1);
        access(1'b0, 32'h4, 4'hF, 32'h0, ar, w);
        idle(6);
        vectors++;
        if (q2.size() != 1 || q3.size() != 1) begin
            miscompares++; $display("FAIL midreset_discard got n2=%0d n3=%0d want 1/1", q2.size(), q3.size());
        end
        vectors++;
        if (q3[0].c != ar + 3 || q3[0].d !== 32'h2) begin
            miscompares++; $display("FAIL midreset_retain got c=%0d d=%h want c=%0d d=2",
                q3[0].c, q3[0].d, ar + 3);
        end
    endtask

`ifdef MEM_GNT_STALL_EN
    task automatic test_stall();
        int c0, a0, a1, w;
        clear_q();
        c0 = cyc;
        access(1'b0, 32'h0, 4'hF, 32'h0, a0, w);
        access(1'b0, 32'h4, 4'hF, 32'h0, a1, w);
        idle(5);
        vectors++;
        if (a0 != c0 + 2 || a1 != c0 + 5) begin
            miscompares++; $display("FAIL stall_gnt got +%0d/+%0d want +2/+5", a0 - c0, a1 - c0);
        end
        vectors++;
        if (q1[0].c != c0 + 3 || q1[0].d !== 32'h1) begin
            miscompares++; $display("FAIL stall_rvalid got +%0d d=%h want +3 d=1", q1[0].c - c0, q1[0].d);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        test_reset();
        test_read_after_write();
        test_byte_enable();
        test_out_of_range();
        test_back_to_back();
        test_reset_midflight();
`ifdef MEM_GNT_STALL_EN
        test_stall();
`endif
        vectors++;
        if (idle_bad != 0) begin
            miscompares++; $display("FAIL idle_outputs got %0d nonzero idle samples want 0", idle_bad);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no completion want finish before 200000");
        $fatal(1);
    end
endmodule
